// File: rtl/vga_timing_rx.sv
// vga_timing_rx
//   Recovers pixel coordinates and a data-enable from an incoming active-low
//   VGA sync pair. Line and frame lengths are measured continuously; a lock
//   FSM (UNLOCKED -> H_LOCKED -> V_ALIGN -> LOCKED) gates de so video is only
//   flagged once both horizontal and vertical timing have been confirmed.
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high
//   hsync_in     horizontal sync, active low
//   vsync_in     vertical sync, active low
//   x, y         recovered column/row (0 when de=0)
//   de           visible pixel while locked
//   frame_start  one-cycle pulse on the first visible pixel of a frame
//   locked       lock FSM is in LOCKED
//   err          one-cycle pulse on a timing violation that drops lock state
//   h_meas       last measured line length (clocks)
//   v_meas       last measured frame length (lines)
//
// Build option
//   VGA_RX_SYNC2FF_EN : adds a 2-flop synchronizer (reset to 1) in front of
//   the input stage for sources asynchronous to clk. Adds 2 cycles latency.
module vga_timing_rx #(
  parameter int H_TOTAL    = 800,
  parameter int H_START    = 144,
  parameter int H_VISIBLE  = 640,
  parameter int V_TOTAL    = 525,
  parameter int V_START    = 35,
  parameter int V_VISIBLE  = 480,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_H_LOCKED = 2'd1;
  localparam logic [1:0] ST_V_ALIGN  = 2'd2;
  localparam logic [1:0] ST_LOCKED   = 2'd3;

  localparam int CW = (LOCK_LINES < 2) ? 1 : $clog2(LOCK_LINES + 1);

  localparam logic [10:0] CNT_SAT = 11'h7FF;
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_VISIBLE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_VISIBLE);

  // ---------------- input stage ----------------
  logic hs_src, vs_src;

`ifdef VGA_RX_SYNC2FF_EN
  logic [1:0] hs_sync_q, vs_sync_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync_q <= 2'b11;
      vs_sync_q <= 2'b11;
    end else begin
      hs_sync_q <= {hs_sync_q[0], hsync_in};
      vs_sync_q <= {vs_sync_q[0], vsync_in};
    end
  end
  assign hs_src = hs_sync_q[1];
  assign vs_src = vs_sync_q[1];
`else
  assign hs_src = hsync_in;
  assign vs_src = vsync_in;
`endif

  // bit 1 = hsync, bit 0 = vsync
  logic [1:0] s1_q, s1_prev_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 2'b11;
      s1_prev_q <= 2'b11;
    end else begin
      s1_q      <= {hs_src, vs_src};
      s1_prev_q <= s1_q;
    end
  end

  logic hfall, vfall;
  assign hfall = s1_prev_q[1] & ~s1_q[1];
  assign vfall = s1_prev_q[0] & ~s1_q[0];

  // ---------------- counters / measurement ----------------
  logic [10:0] hpos_q, hpos_d, vline_q, vline_d;
  logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic [10:0] hpos_inc, frame_len;
  logic        h_good, h_tmo, bad_line, frame_ok;

  assign hpos_inc  = hpos_q + 11'd1;
  assign h_good    = hfall && (hpos_inc == H_TOT);
  // Timeout fires on the step into saturation, so it flags only once.
  assign h_tmo     = !hfall && (hpos_q == CNT_SAT - 11'd1);
  assign bad_line  = (hfall && !h_good) || h_tmo;
  // A coincident hsync edge closes the last line of the frame as well.
  assign frame_len = hfall ? (vline_q + 11'd1) : vline_q;
  assign frame_ok  = (frame_len == V_TOT);

  always_comb begin
    hpos_d   = (hpos_q == CNT_SAT) ? CNT_SAT : hpos_inc;
    h_meas_d = h_meas_q;
    vline_d  = vline_q;
    v_meas_d = v_meas_q;
    if (hfall) begin
      hpos_d   = 11'd0;
      h_meas_d = hpos_inc;
      if (vline_q != CNT_SAT) vline_d = vline_q + 11'd1;
    end
    if (vfall) begin
      vline_d  = 11'd0;
      v_meas_d = frame_len;
    end
  end

  // ---------------- lock FSM ----------------
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] good_cnt_q, good_cnt_d;
  logic          err_evt, err_evt_q;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_evt    = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (bad_line) good_cnt_d = '0;
        else if (h_good) begin
          if (good_cnt_q == CW'(LOCK_LINES - 1)) begin
            state_d    = ST_H_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
      end
      ST_H_LOCKED: begin
        if (bad_line) begin
          state_d = ST_UNLOCKED;
          err_evt = 1'b1;
        end else if (vfall) state_d = ST_V_ALIGN;
      end
      ST_V_ALIGN: begin
        if (bad_line) begin
          state_d = ST_UNLOCKED;
          err_evt = 1'b1;
        end else if (vfall && frame_ok) state_d = ST_LOCKED;
      end
      default: begin // ST_LOCKED
        if (bad_line) begin
          state_d = ST_UNLOCKED;
          err_evt = 1'b1;
        end else if (vfall && !frame_ok) begin
          state_d = ST_V_ALIGN;
          err_evt = 1'b1;
        end
      end
    endcase
  end

  // ---------------- output decode ----------------
  logic        de_d, fs_d;
  logic [10:0] hrel, vrel;
  logic [9:0]  x_d, y_d;

  assign hrel = hpos_q - H_LO;
  assign vrel = vline_q - V_LO;
  assign de_d = (state_q == ST_LOCKED) &&
                (hpos_q  >= H_LO) && (hpos_q  < H_HI) &&
                (vline_q >= V_LO) && (vline_q < V_HI);
  assign fs_d = de_d && (hpos_q == H_LO) && (vline_q == V_LO);
  assign x_d  = de_d ? hrel[9:0] : 10'd0;
  assign y_d  = de_d ? vrel[9:0] : 10'd0;

  logic [9:0] x_q, y_q;
  logic       de_q, fs_q, locked_q, err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q     <= '0;
      vline_q    <= '0;
      h_meas_q   <= '0;
      v_meas_q   <= '0;
      state_q    <= ST_UNLOCKED;
      good_cnt_q <= '0;
      err_evt_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hpos_q     <= hpos_d;
      vline_q    <= vline_d;
      h_meas_q   <= h_meas_d;
      v_meas_q   <= v_meas_d;
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_evt_q  <= err_evt;
      x_q        <= x_d;
      y_q        <= y_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
      // Status follows the state register, so it trails a transition by one edge.
      locked_q   <= (state_q == ST_LOCKED);
      err_q      <= err_evt_q;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;

endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Recovers pixel coordinates and a data-enable from an incoming 640×480@60 VGA sync pair (hsync_in/vsync_in, active low) on the 25 MHz pixel clock. It is the receiving end of the VGA timing protocol, used for loopback checking of the sync generator and for capture of external video. It measures line and frame lengths, runs a lock state machine, and only asserts `de` once timing is confirmed.

## Interface
- H_TOTAL, 800: expected clocks per line
- H_START, 144: hpos of first visible pixel (sync 96 + back porch 48)
- H_VISIBLE, 640: visible pixels per line
- V_TOTAL, 525: expected lines per frame
- V_START, 35: vline of first visible line (sync 2 + back porch 33)
- V_VISIBLE, 480: visible lines per frame
- LOCK_LINES, 4: consecutive good lines needed to leave UNLOCKED
- clk  in  1  pixel clock; reset is synchronous, active-high; clock clk
- reset  in  1  synchronous, active-high
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- x  out  10  recovered column, 0..639; 0 when de=0
- y  out  10  recovered row, 0..479; 0 when de=0
- de  out  1  visible pixel and locked
- frame_start  out  1  one-cycle pulse with de, x=0, y=0
- locked  out  1  state==LOCKED
- err  out  1  one-cycle pulse on any timing violation
- h_meas  out  11  last measured line length in clocks
- v_meas  out  11  last measured frame length in lines

## Operation
- Input stage s1 samples hsync_in/vsync_in. Falling edges: hfall = s1_prev & ~s1, and vfall likewise.
- hpos (11 b): 0 on hfall, else +1, saturating at 2047. On hfall, h_meas <= hpos+1.
- vline (11 b): +1 on hfall; 0 on vfall.
  - vfall alone: v_meas <= vline.
  - vfall coincident with hfall: vline <= 0 (vsync wins) and v_meas <= vline+1.
- A line is good when hfall occurs with hpos+1 == H_TOTAL. A line is bad on any other hfall, or when hpos reaches 2047 (timeout). A timeout flags once, then hpos stays saturated until the next hfall.
- FSM states and transitions:
  - UNLOCKED: count consecutive good lines. A bad line clears the count. At LOCK_LINES -> H_LOCKED.
  - H_LOCKED: on vfall -> V_ALIGN.
  - V_ALIGN: on next vfall, measured frame == V_TOTAL -> LOCKED; otherwise stay.
  - LOCKED: frame != V_TOTAL at vfall -> V_ALIGN with err.
  - Any bad line in H_LOCKED, V_ALIGN or LOCKED -> UNLOCKED with err. A bad line in UNLOCKED gives no err.
- de_next = LOCKED & H_START ≤ hpos < H_START+H_VISIBLE & V_START ≤ vline < V_START+V_VISIBLE.
- x = hpos−H_START and y = vline−V_START, truncated to 10 b.
- x, y, de, frame_start, locked, err are registered.
- Reset: all outputs 0, h_meas=v_meas=0, hpos=vline=0, s1=s1_prev=1, state UNLOCKED, good-line count 0. Reset mid-frame takes effect at the next edge and overrides everything.

## Timing
- Let F be the edge at which hsync_in is first sampled low.
  - hpos=0 after edge F+1; h_meas updates at F+1.
  - First de=1, x=0 after edge F+H_START+2, i.e. F+146.
- de is high for exactly H_VISIBLE consecutive cycles per visible line.
- State change on a bad line happens at the hfall/timeout edge. de, locked and err reflect it one edge later; de drops that same edge.
- err is a single-cycle pulse. Simultaneous bad line and bad frame produce one err pulse and the next state is UNLOCKED.
- Lock from reset with a clean source: LOCK_LINES good lines, then the first vfall, then one full frame. locked rises one edge after the second vfall.

## Configuration
- VGA_RX_SYNC2FF_EN defined: a 2-flop synchronizer (reset to 1) sits ahead of s1 on both inputs. All input-referenced latencies grow by 2 (first de at F+148). Use this for asynchronous external sources.
- Undefined: inputs go straight to s1. Inputs must be synchronous to clk.

## Test plan
- Reset, then a nominal 800×525 source (hsync low 96, vsync low 2 lines) -> locked=1 one edge after the second vfall, err never pulses, h_meas=800, v_meas=525.
- Locked, hsync first low at F on the line where vline becomes 35 -> at F+146: de=1, x=0, y=0, frame_start=1. de stays high 640 cycles, last x=639, y=0. The last visible line has y=479.
- Locked, one line stretched to 801 clocks -> one-cycle err, locked=0, de=0, h_meas=801. Relock after 4 good lines + vfall + a 525-line frame.
- hsync_in held high after lock -> err once when hpos hits 2047, state UNLOCKED, de stays 0.
- Locked, one 526-line frame -> err, v_meas=526, locked=0 (V_ALIGN). The next 525-line frame sets locked=1 without a new line count.
- Reset asserted mid-frame while locked -> after the next edge all outputs are 0 and locked=0. Relock proceeds as in the first test.
